axis_frame_arbiter: RTL

Frame-granular round-robin arbiter that shares the single MAC TX AXI-Stream input between NUM_PORTS requesters (for example, host data, pause-frame generator and test-pattern source). It grants one requester at a time and holds the grant until that requester's tlast beat completes. It never interleaves beats of different frames. It sits directly upstream of the MAC TX AXI-Stream slave, and the downstream trdy is passed through to the granted port.

---
 rtl/axis_frame_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
// Frame-granular round-robin arbiter feeding the single MAC TX AXI-Stream
// input from NUM_PORTS requesters. A grant is taken in IDLE, held for the
// whole frame in XFER, and released after the tlast beat is accepted.
//
// Optional feature macro: ARB_IFG_EN
//   defined   -> a GAP state forces IFG_CYCLES idle cycles after every tlast
//   undefined -> XFER returns straight to IDLE and IFG_CYCLES is ignored
//
// Handshake: a beat moves on any cycle where valid and ready are both high
// at the rising edge of clk. Valid never waits on ready. Downstream
// m_axis_trdy is passed combinationally to the granted port only. The
// master side is driven only in XFER and is all-zero in every other state.
//
// dbg_state exposes the FSM encoding (0 IDLE, 1 XFER, 2 GAP) for checkers.
module axis_frame_arbiter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_PORTS  = 4,
    parameter  int IFG_CYCLES = 3,
    localparam int GW         = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_trdy,
    output logic [GW-1:0]                   grant_id,
    output logic                            busy,
    output logic [1:0]                      dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ARB_IFG_EN
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
`else
        ST_XFER = 2'd1
`endif
    } state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] rr_sel;
    logic          rr_found;
    logic          beat_last_done;

`ifdef ARB_IFG_EN
    localparam int CW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    logic [CW-1:0] ifg_cnt;
`endif

    assign dbg_state = state;

    // Round-robin search: first requester after last_grant, wrapping around,
    // so the port granted last has the lowest priority next time.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            logic [GW-1:0] idx;
            idx = GW'((int'(last_grant) + i) % NUM_PORTS);
            if (!rr_found && s_axis_tvalid[idx]) begin
                rr_found = 1'b1;
                rr_sel   = idx;
            end
        end
    end

    // Zero-latency mux of the granted port onto the master side; ready is
    // routed back to the granted port only, and everything idles outside XFER.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_trdy   = '0;
        if (state == ST_XFER) begin
            m_axis_tdata            = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            m_axis_tlast            = s_axis_tlast[grant_id];
            s_axis_trdy[grant_id]   = m_axis_trdy;
        end
    end

    // The frame ends on the accepted tlast beat; a stalled requester simply
    // keeps the grant because nothing here times out.
    assign beat_last_done = m_axis_tvalid & m_axis_trdy & m_axis_tlast;

    // Arbitration FSM with registered grant_id and busy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_PORTS - 1);
            busy       <= 1'b0;
`ifdef ARB_IFG_EN
            ifg_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_id   <= rr_sel;
                        last_grant <= rr_sel;
                        state      <= ST_XFER;
                        busy       <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (beat_last_done) begin
`ifdef ARB_IFG_EN
                        state   <= ST_GAP;
                        ifg_cnt <= CW'(IFG_CYCLES - 1);
                        busy    <= 1'b1;
`else
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
`endif
                    end
                end
`ifdef ARB_IFG_EN
                ST_GAP: begin
                    if (ifg_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ifg_cnt <= ifg_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
